rx_letter_fifo: RTL and testbench
=================================

RX_LETTER_FIFO -- requirements
Module: rx_letter_fifo

Interface
REQ-001 SHALL have parameter LETTER_W, default 5, bits per letter.
REQ-002 SHALL have parameter DEPTH, default 1024, entries (power of two, >=2).
REQ-003 SHALL have parameter OVERWRITE, default 0, full policy (0 = drop newest, 1 = overwrite oldest).
REQ-004 SHALL have parameter EDGE_VALID, default 1, write qualifier (1 = accept on rising edge of wr_valid_in only, 0 = accept every high cycle).
REQ-005 SHALL have parameter HOLD_N, default 2, letters kept in the debug history.
REQ-006 SHALL have port clk_in, input, 1, the single clock.
REQ-007 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clear_in, input, 1, synchronous flush.
REQ-009 SHALL have port wr_data_in, input, LETTER_W, decoded letter.
REQ-010 SHALL have port wr_valid_in, input, 1, letter qualifier.
REQ-011 SHALL have port rd_ready_in, input, 1, consumer ready.
REQ-012 SHALL have port rd_valid_out, output, 1, head entry valid.
REQ-013 SHALL have port rd_data_out, output, LETTER_W, head entry.
REQ-014 SHALL have port count_out, output, $clog2(DEPTH)+1, occupancy.
REQ-015 SHALL have ports full_out and empty_out, output, 1 each, status.
REQ-016 SHALL have port overflow_out, output, 1, sticky loss flag.
REQ-017 SHALL have port hold_out, output, HOLD_N*LETTER_W, last accepted letters with the newest in the LSBs.

Function
REQ-018 An accept SHALL be wr_valid_in high (EDGE_VALID=0) or a low-to-high transition against the previous cycle's wr_valid_in (EDGE_VALID=1).
REQ-019 A read SHALL occur on a cycle with rd_valid_out and rd_ready_in both high, and SHALL advance the head by one.
REQ-020 An accept into a non-full FIFO SHALL store the letter at the tail, increment count_out, and raise rd_valid_out on the next cycle if the FIFO was empty (latency 1).
REQ-021 rd_data_out SHALL equal the oldest stored letter whenever rd_valid_out is high, and rd_valid_out SHALL equal !empty_out.
REQ-022 An accept and a read in the same cycle while non-empty SHALL leave count_out unchanged, including when full.
REQ-023 An accept while full with no read and OVERWRITE=0 SHALL discard the letter, leave the contents unchanged, and set overflow_out.
REQ-024 An accept while full with no read and OVERWRITE=1 SHALL discard the oldest entry, store the new letter, keep count_out at DEPTH, and set overflow_out.
REQ-025 A read while empty SHALL have no effect.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 full_out SHALL be high iff count_out==DEPTH, and empty_out SHALL be high iff count_out==0.
REQ-028 Every accept, including a dropped one, SHALL shift wr_data_in into hold_out.
REQ-029 clear_in SHALL, on the next edge, zero count_out, pointers, overflow_out and hold_out, and SHALL override a simultaneous accept or read.
REQ-030 clear_in SHALL NOT clear the edge-detect history, so a wr_valid_in held high across a clear is not re-accepted.
REQ-031 overflow_out SHALL clear only on clear_in or reset.

Reset
REQ-032 rst_in low SHALL asynchronously force count_out=0, empty_out=1, full_out=0, rd_valid_out=0, overflow_out=0, hold_out=0, and edge history=0.
REQ-033 Reset SHALL force rd_data_out to 0.
REQ-034 The storage array SHALL NOT be reset, so that it infers BRAM.
REQ-035 Reset asserted mid-operation SHALL discard all contents.
REQ-036 The first accept after reset release SHALL be honoured.

Structure
REQ-037 A shared package SHALL hold the default letter width constant (5) and an overflow-policy enum (DROP_NEWEST, OVERWRITE_OLDEST), with OVERWRITE mapped to it.
REQ-038 The rising-edge qualifier SHALL be a sub-module named valid_edge_detect, with clk_in, rst_in, sig_in and pulse_out.

Verification (DEPTH=4, EDGE_VALID=1 unless stated)
REQ-039 Pulse in letters 3,7,11 with rd_ready_in=0 -> count_out=3, rd_data_out=3; then hold rd_ready_in=1 -> reads 3,7,11 on consecutive cycles, then empty_out=1.
REQ-040 OVERWRITE=0: write 1,2,3,4,5 -> full_out=1, overflow_out=1, reads 1,2,3,4, hold_out low letter=5.
REQ-041 OVERWRITE=1: write 1,2,3,4,5 -> count_out=4, overflow_out=1, reads 2,3,4,5.
REQ-042 Full FIFO with accept and read on the same cycle -> count_out stays 4 and the new letter is read last.
REQ-043 wr_valid_in held high for 10 cycles -> exactly one accept. With EDGE_VALID=0 the same stimulus into an empty FIFO -> 4 stored and 6 handled per REQ-023.
REQ-044 clear_in coincident with an accept of 9 -> count_out=0, overflow_out=0, hold_out=0. Asserting rst_in low mid-burst -> outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/rx_letter_fifo_pkg.sv
// rx_letter_fifo_pkg
//   Shared constants and types for the received-letter FIFO.
//   - LETTER_W_DEFAULT : default bits per decoded letter
//   - ovf_policy_e     : what a full FIFO does with a new letter
//   - policy_from_param: maps the integer OVERWRITE parameter onto the enum
package rx_letter_fifo_pkg;

  localparam int LETTER_W_DEFAULT = 5;

  typedef enum logic {
    DROP_NEWEST      = 1'b0,
    OVERWRITE_OLDEST = 1'b1
  } ovf_policy_e;

  function automatic ovf_policy_e policy_from_param(input int overwrite);
    return (overwrite != 0) ? OVERWRITE_OLDEST : DROP_NEWEST;
  endfunction

endpackage

// File: rtl/rx_letter_fifo_valid_edge_detect.sv
// valid_edge_detect
//   One-cycle pulse on a low-to-high transition of sig_in, measured against
//   the value seen on the previous clock edge. The history register is only
//   cleared by reset, so a level held high across a FIFO flush is not
//   reported again.
//   Ports:
//     clk_in    : clock
//     rst_in    : asynchronous active-low reset (history forced to 0)
//     sig_in    : level to watch
//     pulse_out : high while sig_in is high and was low on the previous edge
module valid_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic pulse_out
);

  logic prev_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_in;
    end
  end

  assign pulse_out = sig_in && !prev_q;

endmodule

// File: rtl/rx_letter_fifo.sv
// rx_letter_fifo
//   Buffers decoded letters between a receiver and a consumer.
//   Handshake: the head entry is offered with rd_valid_out; a read happens on
//   any cycle where rd_valid_out and rd_ready_in are both high. The writer has
//   no backpressure: a letter is accepted on a wr_valid_in rising edge
//   (EDGE_VALID=1) or on every high cycle (EDGE_VALID=0); when full it is
//   either dropped or replaces the oldest entry, and overflow_out sticks.
//   Ports:
//     clk_in, rst_in (async active-low), clear_in (sync flush)
//     wr_data_in / wr_valid_in   : incoming letter and its qualifier
//     rd_ready_in                : consumer ready
//     rd_valid_out / rd_data_out : head entry (data is 0 while empty)
//     count_out, full_out, empty_out, overflow_out : status
//     hold_out                   : last HOLD_N accepted letters, newest in LSBs
module rx_letter_fifo
  import rx_letter_fifo_pkg::*;
#(
  parameter int LETTER_W   = LETTER_W_DEFAULT,
  parameter int DEPTH      = 1024,
  parameter int OVERWRITE  = 0,
  parameter int EDGE_VALID = 1,
  parameter int HOLD_N     = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clear_in,
  input  logic [LETTER_W-1:0]          wr_data_in,
  input  logic                         wr_valid_in,
  input  logic                         rd_ready_in,
  output logic                         rd_valid_out,
  output logic [LETTER_W-1:0]          rd_data_out,
  output logic [$clog2(DEPTH):0]       count_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         overflow_out,
  output logic [HOLD_N*LETTER_W-1:0]   hold_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = HOLD_N * LETTER_W;
  localparam ovf_policy_e POLICY = policy_from_param(OVERWRITE);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage has no reset so it can map onto block RAM.
  logic [LETTER_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          accept, rd_fire, full, empty, mem_we;

  if (EDGE_VALID != 0) begin : g_edge
    valid_edge_detect u_edge (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .sig_in    (wr_valid_in),
      .pulse_out (accept)
    );
  end else begin : g_level
    assign accept = wr_valid_in;
  end

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign rd_fire = !empty && rd_ready_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    hold_d   = hold_q;
    mem_we   = 1'b0;

    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      hold_d   = '0;
    end else begin
      // Dropped letters still enter the history.
      if (accept) hold_d = (hold_q << LETTER_W) | HW'(wr_data_in);

      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);

      if (accept) begin
        // A same-cycle read frees the head slot, so a full FIFO can still
        // take the letter; when full, wr_ptr == rd_ptr and the slot being
        // written is the one just read out.
        if (rd_fire || !full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          ovf_d = 1'b1;
          if (POLICY == OVERWRITE_OLDEST) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end

      if (accept && !full && !rd_fire) begin
        count_d = count_q + CW'(1);
      end else if (rd_fire && !accept) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
    end
  end

  assign rd_valid_out = !empty;
  assign rd_data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_out    = count_q;
  assign full_out     = full;
  assign empty_out    = empty;
  assign overflow_out = ovf_q;
  assign hold_out     = hold_q;

endmodule

// File: tb/tb_rx_letter_fifo.sv
// Three DEPTH=4 instances share one stimulus stream:
//   0: drop newest, edge qualifier   1: overwrite oldest, edge qualifier
//   2: drop newest, level qualifier
// Each is compared every cycle against an ordered-list model of its policy.
module tb_rx_letter_fifo;

  localparam int W = 5;
  localparam int D = 4;
  localparam int N = 3;
  localparam bit OVW [N] = '{1'b0, 1'b1, 1'b0};
  localparam bit EDG [N] = '{1'b1, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clear, wr_valid, rd_ready;
  logic [W-1:0] wr_data;

  logic         rd_valid [N];
  logic [W-1:0] rd_data  [N];
  logic [2:0]   count    [N];
  logic         full     [N];
  logic         empty    [N];
  logic         ovf      [N];
  logic [9:0]   hold     [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    rx_letter_fifo #(
      .LETTER_W   (W),
      .DEPTH      (D),
      .OVERWRITE  ((g == 1) ? 1 : 0),
      .EDGE_VALID ((g == 2) ? 0 : 1),
      .HOLD_N     (2)
    ) u_dut (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .clear_in     (clear),
      .wr_data_in   (wr_data),
      .wr_valid_in  (wr_valid),
      .rd_ready_in  (rd_ready),
      .rd_valid_out (rd_valid[g]),
      .rd_data_out  (rd_data[g]),
      .count_out    (count[g]),
      .full_out     (full[g]),
      .empty_out    (empty[g]),
      .overflow_out (ovf[g]),
      .hold_out     (hold[g])
    );
  end

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each FIFO is an ordered list, index 0 = oldest letter.
  int         m_cnt  [N];
  logic [W-1:0] m_list [N][D];
  logic       m_ovf  [N];
  logic [9:0] m_hold [N];
  logic       m_prev [N];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k]  = 0;
      m_ovf[k]  = 1'b0;
      m_hold[k] = '0;
      m_prev[k] = 1'b0;
    end
  endtask

  task automatic model_pop(input int k);
    for (int i = 0; i < D - 1; i++) m_list[k][i] = m_list[k][i+1];
    m_cnt[k]--;
  endtask

  task automatic model_push(input int k, input logic [W-1:0] d);
    m_list[k][m_cnt[k]] = d;
    m_cnt[k]++;
  endtask

  // Applies the inputs present at a clock edge.
  task automatic model_edge();
    logic acc, rd;
    for (int k = 0; k < N; k++) begin
      acc = EDG[k] ? (wr_valid && !m_prev[k]) : wr_valid;
      m_prev[k] = wr_valid;
      if (clear) begin
        m_cnt[k]  = 0;
        m_ovf[k]  = 1'b0;
        m_hold[k] = '0;
      end else begin
        rd = (m_cnt[k] > 0) && rd_ready;
        if (acc) m_hold[k] = {m_hold[k][4:0], wr_data};
        if (rd) model_pop(k);
        if (acc) begin
          if (m_cnt[k] < D) begin
            model_push(k, wr_data);
          end else begin
            m_ovf[k] = 1'b1;
            if (OVW[k]) begin
              model_pop(k);
              model_push(k, wr_data);
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("count%0d", k), 32'(count[k]), 32'(m_cnt[k]));
      check($sformatf("empty%0d", k), 32'(empty[k]), 32'(m_cnt[k] == 0));
      check($sformatf("full%0d", k), 32'(full[k]), 32'(m_cnt[k] == D));
      check($sformatf("rd_valid%0d", k), 32'(rd_valid[k]), 32'(m_cnt[k] != 0));
      check($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
      check($sformatf("hold%0d", k), 32'(hold[k]), 32'(m_hold[k]));
      if (m_cnt[k] > 0)
        check($sformatf("rd_data%0d", k), 32'(rd_data[k]), 32'(m_list[k][0]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_count%0d", tag, k), 32'(count[k]), 0);
      check($sformatf("%s_empty%0d", tag, k), 32'(empty[k]), 1);
      check($sformatf("%s_full%0d", tag, k), 32'(full[k]), 0);
      check($sformatf("%s_rd_valid%0d", tag, k), 32'(rd_valid[k]), 0);
      check($sformatf("%s_ovf%0d", tag, k), 32'(ovf[k]), 0);
      check($sformatf("%s_hold%0d", tag, k), 32'(hold[k]), 0);
      check($sformatf("%s_rd_data%0d", tag, k), 32'(rd_data[k]), 0);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, check at the falling edge,
  // advance the model at the rising edge, settle.
  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy, input logic clr);
    wr_valid = v;
    wr_data  = d;
    rd_ready = rdy;
    clear    = clr;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] d, input logic rdy);
    step(1'b1, d, rdy, 1'b0);
    step(1'b0, d, rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    #3 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Three letters buffered, then drained with ready held high.
    pulse(5'd3, 1'b0); pulse(5'd7, 1'b0); pulse(5'd11, 1'b0);
    check("s1_count", 32'(count[0]), 3);
    check("s1_head", 32'(rd_data[0]), 3);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("s1_empty", 32'(empty[0]), 1);

    // Five letters into four slots: drop vs overwrite.
    for (int i = 1; i <= 5; i++) pulse(W'(i), 1'b0);
    check("s2_full", 32'(full[0]), 1);
    check("s2_ovf", 32'(ovf[0]), 1);
    check("s2_hold_lo", 32'(hold[0][4:0]), 5);
    check("s2_head_drop", 32'(rd_data[0]), 1);
    check("s2_count_ovw", 32'(count[1]), 4);
    check("s2_head_ovw", 32'(rd_data[1]), 2);

    // Accept and read together while full.
    step(1'b1, 5'd9, 1'b1, 1'b0);
    check("s3_count_drop", 32'(count[0]), 4);
    check("s3_count_ovw", 32'(count[1]), 4);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // wr_valid held high for ten cycles.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 5'd6, 1'b0, 1'b0);
    check("s4_edge_count", 32'(count[0]), 1);
    check("s4_level_count", 32'(count[2]), 4);
    check("s4_level_ovf", 32'(ovf[2]), 1);
    check("s4_edge_ovf", 32'(ovf[0]), 0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Clear coincident with an accept, then valid kept high past the clear.
    pulse(5'd4, 1'b0);
    step(1'b1, 5'd9, 1'b1, 1'b1);
    check("s5_count", 32'(count[0]), 0);
    check("s5_ovf", 32'(ovf[2]), 0);
    check("s5_hold", 32'(hold[0]), 0);
    step(1'b1, 5'd9, 1'b0, 1'b0);
    check("s5_no_reaccept", 32'(count[0]), 0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic; the first half reads rarely to reach full.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom_range(0, 31)),
           (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0));
    end

    // Reset asserted mid-burst with wr_valid high.
    for (int i = 0; i < 3; i++) pulse(W'(20 + i), 1'b0);
    wr_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 5'd17, 1'b0, 1'b0);
    check("rel_first_accept", 32'(count[0]), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
